// File: rtl/emmc_resp_rx.sv
// ============================================================================
//  Module   : emmc_resp_rx (with jedec_p response types)
//  Brief    : eMMC CMD-line response receiver for R1/R1b/R3 (48-bit) and
//             R2 (136-bit) frames: start-bit detection, Ncr timeout,
//             deserialisation, framing and CRC7 checks.
//             Optional macro EMMC_RESP_CRC_EN builds the CRC7 checker.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package jedec_p;
    localparam int FULL_RESPONSE_WIDTH = 128;

    typedef struct packed {
        logic       address_out_of_range;
        logic       address_misalign;
        logic       block_len_error;
        logic       erase_seq_error;
        logic       erase_param;
        logic       wp_violation;
        logic       card_is_locked;
        logic       lock_unlock_failed;
        logic       com_crc_error;
        logic       illegal_command;
        logic       card_ecc_failed;
        logic       cc_error;
        logic       error;
        logic [1:0] rsvd_18_17;
        logic       cid_csd_overwrite;
        logic       wp_erase_skip;
        logic       rsvd_14;
        logic       erase_reset;
        logic [3:0] current_state;
        logic       ready_for_data;
        logic       switch_error;
        logic       exception_event;
        logic       app_cmd;
        logic [4:0] rsvd_4_0;
    } card_status_t;

    typedef struct packed {
        logic       busy;
        logic [1:0] access_mode;
        logic [4:0] rsvd_28_24;
        logic [8:0] vdd_27_36;
        logic [6:0] rsvd_14_8;
        logic       vdd_170_195;
        logic [6:0] rsvd_6_0;
    } ocr_t;

    typedef struct packed {
        logic [7:0]  mid;
        logic [5:0]  rsvd_119_114;
        logic [1:0]  cbx;
        logic [7:0]  oid;
        logic [47:0] pnm;
        logic [7:0]  prv;
        logic [31:0] psn;
        logic [7:0]  mdt;
        logic [6:0]  crc;
        logic        rsvd_0;
    } cid_t;

    typedef struct packed {
        logic [1:0]   csd_structure;
        logic [3:0]   spec_vers;
        logic [113:0] body;
        logic [6:0]   crc;
        logic         rsvd_0;
    } csd_t;
endpackage

module emmc_resp_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    bit_en_i,
    input  logic                                    cmd_i,
    input  logic                                    start_i,
    input  logic                                    long_i,
    input  logic                                    crc_chk_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    output logic                                    timeout_o,
    output logic                                    crc_err_o,
    output logic                                    frame_err_o,
    output logic [5:0]                              index_o,
    output logic [jedec_p::FULL_RESPONSE_WIDTH-1:0] resp_o,
    output jedec_p::card_status_t                   status_o
);
    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  C_LONG_CNT  = 8'd134;
    localparam logic [7:0]  C_SHORT_CNT = 8'd46;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECV       = 2'd2,
        CHECK      = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic           long_q, long_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [7:0]     bcnt_q, bcnt_d;
    logic [133:0]   shift_q, shift_d;
    logic           timeout_q, timeout_d;
    logic           crc_err_q, crc_err_d;
    logic           frame_err_q, frame_err_d;
    logic [5:0]     index_q, index_d;
    logic [127:0]   resp_q, resp_d;

    logic [134:0]   w_frame;
    logic [TW-1:0]  w_tcnt_inc;
    logic           w_crc_bad;

    // Everything after the start bit, with the bit currently on the line as LSB.
    assign w_frame    = {shift_q, cmd_i};
    assign w_tcnt_inc = tcnt_q + TW'(1);

`ifdef EMMC_RESP_CRC_EN
    logic           crc_chk_q, crc_chk_d;
    logic [6:0]     crc_q, crc_d;

    always_comb begin
        crc_chk_d = crc_chk_q;
        crc_d     = crc_q;
        if (state_q == IDLE && start_i) begin
            crc_chk_d = crc_chk_i;
        end
        // A zero start bit into a zero register leaves it zero, so clearing seeds it.
        if (state_q == WAIT_START && bit_en_i && !cmd_i) begin
            crc_d = 7'd0;
        end else if (state_q == RECV && bit_en_i && bcnt_q >= 8'd8 && bcnt_q <= 8'd127) begin
            crc_d = {crc_q[5:0], 1'b0} ^ ({7{crc_q[6] ^ cmd_i}} & 7'h09);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_chk_q <= 1'b0;
            crc_q     <= 7'd0;
        end else begin
            crc_chk_q <= crc_chk_d;
            crc_q     <= crc_d;
        end
    end

    assign w_crc_bad = crc_chk_q && (crc_q != w_frame[7:1]);
`else
    logic w_unused_crc_chk;
    assign w_unused_crc_chk = crc_chk_i;
    assign w_crc_bad        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        timeout_d   = timeout_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        index_d     = index_q;
        resp_d      = resp_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    long_d      = long_i;
                    timeout_d   = 1'b0;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    index_d     = 6'd0;
                    resp_d      = '0;
                    tcnt_d      = '0;
                    state_d     = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bit_en_i) begin
                    if (!cmd_i) begin
                        bcnt_d  = long_q ? C_LONG_CNT : C_SHORT_CNT;
                        shift_d = '0;
                        state_d = RECV;
                    end else begin
                        tcnt_d = w_tcnt_inc;
                        if (w_tcnt_inc == TW'(TIMEOUT_CYCLES)) begin
                            timeout_d = 1'b1;
                            state_d   = CHECK;
                        end
                    end
                end
            end
            RECV: begin
                if (bit_en_i) begin
                    shift_d = {shift_q[132:0], cmd_i};
                    bcnt_d  = bcnt_q - 8'd1;
                    if (bcnt_q == 8'd0) begin
                        state_d   = CHECK;
                        crc_err_d = w_crc_bad;
                        if (long_q) begin
                            frame_err_d = w_frame[134] || (w_frame[133:128] != 6'h3F) || !w_frame[0];
                            index_d     = 6'h3F;
                            resp_d      = {w_frame[127:1], 1'b0};
                        end else begin
                            frame_err_d = w_frame[46] || !w_frame[0];
                            index_d     = w_frame[45:40];
                            resp_d      = {96'd0, w_frame[39:8]};
                        end
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            long_q      <= 1'b0;
            tcnt_q      <= '0;
            bcnt_q      <= 8'd0;
            shift_q     <= '0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_q     <= 6'd0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            timeout_q   <= timeout_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            index_q     <= index_d;
            resp_q      <= resp_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == CHECK);
    assign timeout_o   = timeout_q;
    assign crc_err_o   = crc_err_q;
    assign frame_err_o = frame_err_q;
    assign index_o     = index_q;
    assign resp_o      = resp_q;
    assign status_o    = jedec_p::card_status_t'(resp_q[31:0]);

endmodule

`default_nettype wire

// File: tb/tb_emmc_resp_rx.sv
// ============================================================================
//  Module   : tb_emmc_resp_rx
//  Brief    : Scoreboard bench for emmc_resp_rx with a frame-level reference
//             model (CRC7 by polynomial long division).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_emmc_resp_rx;
    logic         clk = 1'b0;
    logic         rst, bit_en_i, cmd_i, start_i, long_i, crc_chk_i;
    logic         busy_o, done_o, timeout_o, crc_err_o, frame_err_o;
    logic [5:0]   index_o;
    logic [127:0] resp_o;
    jedec_p::card_status_t status_o;

    emmc_resp_rx #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .bit_en_i(bit_en_i), .cmd_i(cmd_i),
        .start_i(start_i), .long_i(long_i), .crc_chk_i(crc_chk_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .crc_err_o(crc_err_o), .frame_err_o(frame_err_o),
        .index_o(index_o), .resp_o(resp_o), .status_o(status_o)
    );

    always #5 clk = ~clk;

`ifdef EMMC_RESP_CRC_EN
    localparam bit CRC_BUILT = 1'b1;
`else
    localparam bit CRC_BUILT = 1'b0;
`endif

    typedef struct {
        logic         timeout;
        logic         crc_err;
        logic         frame_err;
        logic [5:0]   index;
        logic [127:0] resp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, message = f[hi] down to f[lo].
    function automatic logic [6:0] crc7_ref(input logic [135:0] f, input int hi, input int lo);
        bit         d [0:143];
        int         n = hi - lo + 1;
        logic [7:0] g = 8'h89;
        logic [6:0] r;
        for (int i = 0; i < 144; i++) d[i] = 1'b0;
        for (int i = 0; i < n; i++) d[i] = f[hi-i];
        for (int i = 0; i < n; i++)
            if (d[i]) for (int j = 0; j < 8; j++) d[i+j] ^= g[7-j];
        for (int i = 0; i < 7; i++) r[6-i] = d[n+i];
        return r;
    endfunction

    function automatic logic [135:0] make_short(input logic [5:0] idx, input logic [31:0] body);
        logic [135:0] f = '0;
        f[47:0]  = {1'b0, 1'b0, idx, body, 7'd0, 1'b1};
        f[7:1]   = crc7_ref(f, 47, 8);
        return f;
    endfunction

    function automatic logic [135:0] make_long(input logic [119:0] body);
        logic [135:0] f;
        f      = {1'b0, 1'b0, 6'h3F, body, 7'd0, 1'b1};
        f[7:1] = crc7_ref(f, 127, 8);
        return f;
    endfunction

    function automatic exp_t model(input logic [135:0] f, input bit lng, input bit crc_on);
        exp_t e;
        int   top = lng ? 135 : 47;
        e.timeout   = 1'b0;
        e.frame_err = (f[top-1] != 1'b0) || (f[0] != 1'b1) || (lng && f[133:128] != 6'h3F);
        e.crc_err   = CRC_BUILT && crc_on && (crc7_ref(f, lng ? 127 : 47, 8) != f[7:1]);
        e.index     = lng ? 6'h3F : f[45:40];
        e.resp      = lng ? {f[127:1], 1'b0} : {96'd0, f[39:8]};
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done_o=1, expected no completion (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("timeout_o", timeout_o, e.timeout);
                chk("crc_err_o", crc_err_o, e.crc_err);
                chk("frame_err_o", frame_err_o, e.frame_err);
                chk("index_o", index_o, e.index);
                chk("resp_o", resp_o, e.resp);
                chk("status_o", status_o, e.resp[31:0]);
            end
        end
    end

    task automatic strobe(input logic b);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            bit_en_i = 1'b0;
            cmd_i    = 1'($urandom);
            @(posedge clk); #1;
        end
        bit_en_i = 1'b1;
        cmd_i    = b;
        @(posedge clk); #1;
        bit_en_i = 1'b0;
        cmd_i    = 1'b1;
    endtask

    task automatic arm(input bit lng, input bit crc_on);
        start_i   = 1'b1;
        long_i    = lng;
        crc_chk_i = crc_on;
        @(posedge clk); #1;
        start_i   = 1'b0;
        long_i    = 1'($urandom);
        crc_chk_i = 1'($urandom);
        chk("busy_rise", busy_o, 1'b1);
        chk("cleared_on_arm", {timeout_o, crc_err_o, frame_err_o, index_o, resp_o}, '0);
    endtask

    task automatic send_frame(input logic [135:0] f, input bit lng, input bit crc_on,
                              input int lead, input int poke);
        int nb = lng ? 136 : 48;
        sb.push_back(model(f, lng, crc_on));
        arm(lng, crc_on);
        repeat (lead) strobe(1'b1);
        for (int i = nb - 1; i >= 0; i--) begin
            if (i == poke) begin
                start_i = 1'b1;
                long_i  = ~lng;
            end
            strobe(f[i]);
            start_i = 1'b0;
            if (i == 1) chk("done_not_early", done_o, 1'b0);
        end
        chk("done_latency", done_o, 1'b1);
        @(posedge clk); #1;
        chk("done_pulse_end", done_o, 1'b0);
        chk("busy_fall", busy_o, 1'b0);
    endtask

    task automatic run_timeout();
        exp_t e;
        e.timeout = 1'b1; e.crc_err = 1'b0; e.frame_err = 1'b0; e.index = 6'd0; e.resp = '0;
        sb.push_back(e);
        arm(1'($urandom), 1'($urandom));
        repeat (63) strobe(1'b1);
        chk("timeout_not_early", done_o, 1'b0);
        strobe(1'b1);
        chk("timeout_done", done_o, 1'b1);
        @(posedge clk); #1;
        chk("timeout_busy_fall", busy_o, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] f;
        bit           lng, crc_on;

        rst = 1'b1; bit_en_i = 1'b0; cmd_i = 1'b1; start_i = 1'b0; long_i = 1'b0; crc_chk_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy_o, done_o, timeout_o, crc_err_o, frame_err_o, index_o, resp_o}, '0);
        chk("reset_status", status_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // R1 CMD13: state 4 (tran), ready_for_data.
        send_frame(make_short(6'd13, 32'h0000_0900), 1'b0, 1'b1, 3, -1);
        chk("r1_current_state", status_o.current_state, 4'd4);
        chk("r1_ready_for_data", status_o.ready_for_data, 1'b1);

        // R2 CID.
        send_frame(make_long(120'h1500_0100_4D4D_4331_3647_3089_ABCD_EF), 1'b1, 1'b1, 5, -1);

        // R3 OCR with all-ones index and CRC fields, CRC check off.
        f = '0;
        f[47:0] = {1'b0, 1'b0, 6'h3F, 32'hC0FF_8080, 7'h7F, 1'b1};
        send_frame(f, 1'b0, 1'b0, 2, -1);

        // Ncr timeout, then the latest accepted start bit.
        run_timeout();
        send_frame(make_short(6'd17, 32'h1234_5678), 1'b0, 1'b1, 63, -1);

        // Error injection: one CRC bit, end bit, transmission bit, R2 check bits.
        f = make_short(6'd7, 32'hDEAD_BEEF); f[3] = ~f[3];
        send_frame(f, 1'b0, 1'b1, 0, -1);
        f = make_short(6'd8, 32'h0BAD_F00D); f[0] = 1'b0;
        send_frame(f, 1'b0, 1'b1, 1, -1);
        f = make_short(6'd9, 32'h0000_0001); f[46] = 1'b1;
        send_frame(f, 1'b0, 1'b1, 1, -1);
        f = make_long(120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32); f[130] = 1'b0;
        send_frame(f, 1'b1, 1'b1, 1, -1);

        // Reset in the middle of an R2 frame.
        arm(1'b1, 1'b1);
        strobe(1'b0);
        for (int i = 0; i < 19; i++) strobe(1'($urandom));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midframe_reset", {busy_o, done_o, timeout_o, crc_err_o, frame_err_o, index_o, resp_o}, '0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // start_i while receiving is ignored.
        send_frame(make_short(6'd3, 32'hA5A5_5A5A), 1'b0, 1'b1, 0, 20);

        // Randomised frames.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                run_timeout();
            end else begin
                lng    = 1'($urandom);
                crc_on = 1'($urandom);
                f = lng ? make_long({$urandom, $urandom, $urandom, 24'($urandom)})
                        : make_short(6'($urandom), $urandom);
                case ($urandom_range(0, 6))
                    0: f[$urandom_range(1, 7)] ^= 1'b1;
                    1: f[0] = 1'b0;
                    2: f[lng ? 134 : 46] = 1'b1;
                    3: if (lng) f[$urandom_range(128, 133)] = 1'b0;
                    default: ;
                endcase
                send_frame(f, lng, crc_on, $urandom_range(0, 63),
                           ($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : -1);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
